// File: rtl/id_stage_p_pkg.sv
// id_stage_p_pkg: opcodes, ALU command codes and the instruction decoder of the decode stage.
package id_stage_p_pkg;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [4:0] OP_ALU  = 5'h01;
  localparam logic [4:0] OP_ADDI = 5'h02;
  localparam logic [4:0] OP_ORI  = 5'h03;
  localparam logic [4:0] OP_LDIH = 5'h04;
  localparam logic [4:0] OP_LD   = 5'h05;
  localparam logic [4:0] OP_ST   = 5'h06;
  localparam logic [4:0] OP_BZ   = 5'h08;
  localparam logic [4:0] OP_BNZ  = 5'h09;
  localparam logic [4:0] OP_BPL  = 5'h0a;
  localparam logic [4:0] OP_JMP  = 5'h0c;
  localparam logic [4:0] OP_JAL  = 5'h0d;
  localparam logic [4:0] OP_JR   = 5'h0e;
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] ALU_OR = 3'd3;
  localparam logic [2:0] THB = 3'd7;
  typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JMP} pc_sel_e;
  typedef enum logic [1:0] {CS_FUNC, CS_THB, CS_ADD, CS_OR} com_sel_e;
  typedef enum logic [1:0] {BS_REG, BS_SEXT8, BS_ZEXT8, BS_HIGH8} bsel_e;
  typedef struct packed {
    pc_sel_e  pc_sel;
    com_sel_e com_sel;
    bsel_e    alu_bsel;
    logic     jr_sel;
    logic     rd_sel;
    logic     rwe;
    logic     st_op;
    logic     ld_op;
    logic     use_a;
    logic     use_b;
  } dec_t;
  function automatic logic links(input logic [4:0] opc);
    return opc == OP_JAL;
  endfunction
  // Branch conditions arrive as flags so pc_sel resolves in the same cycle.
  function automatic dec_t decode(input logic [4:0] opc, input logic zerof, input logic posf);
    dec_t d;
    d = '0;
    d.rd_sel = links(opc);
    case (opc)
      OP_ALU:  begin d.rwe = 1'b1; d.use_a = 1'b1; d.use_b = 1'b1; end
      OP_ADDI: begin d.com_sel = CS_ADD; d.alu_bsel = BS_SEXT8; d.rwe = 1'b1; d.use_a = 1'b1; end
      OP_ORI:  begin d.com_sel = CS_OR; d.alu_bsel = BS_ZEXT8; d.rwe = 1'b1; d.use_a = 1'b1; end
      OP_LDIH: begin d.com_sel = CS_THB; d.alu_bsel = BS_HIGH8; d.rwe = 1'b1; end
      OP_LD:   begin d.com_sel = CS_THB; d.rwe = 1'b1; d.ld_op = 1'b1; d.use_b = 1'b1; end
      OP_ST:   begin d.com_sel = CS_THB; d.st_op = 1'b1; d.use_a = 1'b1; d.use_b = 1'b1; end
      OP_BZ:   begin d.pc_sel = zerof ? PC_BR : PC_SEQ; d.use_a = 1'b1; end
      OP_BNZ:  begin d.pc_sel = zerof ? PC_SEQ : PC_BR; d.use_a = 1'b1; end
      OP_BPL:  begin d.pc_sel = posf ? PC_BR : PC_SEQ; d.use_a = 1'b1; end
      OP_JMP:  d.pc_sel = PC_JMP;
      OP_JAL:  begin d.pc_sel = PC_JMP; d.com_sel = CS_THB; d.rwe = 1'b1; end
      OP_JR:   begin d.pc_sel = PC_JMP; d.jr_sel = 1'b1; d.use_a = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/id_stage_p_regfile.sv
// regfile_p: 8 x DW register file, two asynchronous reads, one synchronous write.
module regfile_p #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ra,
  input  logic [2:0]    rb,
  input  logic          we,
  input  logic [2:0]    wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
);
  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] regs_d [8];
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign qa = regs_q[ra];
  assign qb = regs_q[rb];
endmodule

// File: rtl/id_stage_p.sv
// id_stage_p: decode stage with EX/MEM/WB forwarding, load-use interlock, downstream hold
// and an optional branch delay slot; branches resolve here on the forwarded A operand.
module id_stage_p
  import id_stage_p_pkg::*;
#(
  parameter int DW = 16,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   op,
  input  logic [DW-1:0] pc_next,
  input  logic          hold,
  input  logic [DW-1:0] ex_result,
  input  logic [2:0]    rd_mem,
  input  logic          rwe_mem,
  input  logic [DW-1:0] mem_result,
  input  logic [2:0]    rd_wb,
  input  logic          rwe_wb,
  input  logic [DW-1:0] wb_data,
  output logic          stall_if,
  output logic [1:0]    pc_sel,
  output logic          jr_sel,
  output logic [DW-1:0] jmp8,
  output logic [DW-1:0] jmp11,
  output logic [DW-1:0] jmpr,
  output logic [DW-1:0] areg,
  output logic [DW-1:0] breg,
  output logic [2:0]    com_id,
  output logic          rwe_id,
  output logic          st_op_id,
  output logic          ld_op_id,
  output logic          valid_id,
  output logic [2:0]    rd_id
);
  logic [15:0] ir_q, ir_d;
  logic [DW-1:0] areg_q, areg_d, breg_q, breg_d;
  logic [2:0] rd_id_q, rd_id_d, com_id_q, com_id_d;
  logic rwe_id_q, rwe_id_d, st_op_id_q, st_op_id_d, ld_op_id_q, ld_op_id_d, valid_id_q, valid_id_d;
  logic [DW-1:0] rf_a, rf_b, a_fwd, b_fwd, b_imm, b_val;
  logic [2:0] rd_mod, rs, com;
  logic zerof, posf, ld_use, stall;
  dec_t dec;
  regfile_p #(.DW(DW)) u_rf (
    .clk(clk), .rst_n(rst_n), .ra(rd_mod), .rb(rs),
    .we(rwe_wb), .wa(rd_wb), .wd(wb_data), .qa(rf_a), .qb(rf_b)
  );
  assign rd_mod = links(ir_q[15:11]) ? 3'd7 : ir_q[10:8];
  assign rs = ir_q[7:5];
  // Youngest producer wins: EX, then MEM, then the write-back port, then the array.
  assign a_fwd = (rwe_id_q && rd_id_q == rd_mod) ? ex_result :
                 (rwe_mem && rd_mem == rd_mod) ? mem_result :
                 (rwe_wb && rd_wb == rd_mod) ? wb_data : rf_a;
  assign b_fwd = (rwe_id_q && rd_id_q == rs) ? ex_result :
                 (rwe_mem && rd_mem == rs) ? mem_result :
                 (rwe_wb && rd_wb == rs) ? wb_data : rf_b;
  assign zerof = a_fwd == '0;
  assign posf = !a_fwd[DW-1] && !zerof;
  assign dec = decode(ir_q[15:11], zerof, posf);
  assign ld_use = ld_op_id_q && rwe_id_q &&
                  ((dec.use_a && rd_id_q == rd_mod) || (dec.use_b && rd_id_q == rs));
  assign stall = ld_use || hold;
  always_comb begin
    b_imm = dec.alu_bsel == BS_SEXT8 ? {{(DW-8){ir_q[7]}}, ir_q[7:0]} :
            dec.alu_bsel == BS_ZEXT8 ? DW'(ir_q[7:0]) : DW'({ir_q[7:0], 8'h00});
    com = dec.com_sel == CS_FUNC ? ir_q[2:0] : dec.com_sel == CS_THB ? THB :
          dec.com_sel == CS_ADD ? ADD : ALU_OR;
    b_val = dec.rd_sel ? pc_next : dec.alu_bsel == BS_REG ? b_fwd : b_imm;
    ir_d = stall ? ir_q : (!DELAY_SLOT && dec.pc_sel != PC_SEQ) ? NOP : op;
    areg_d = areg_q;
    breg_d = breg_q;
    rd_id_d = rd_id_q;
    com_id_d = com_id_q;
    rwe_id_d = rwe_id_q;
    st_op_id_d = st_op_id_q;
    ld_op_id_d = ld_op_id_q;
    valid_id_d = valid_id_q;
    if (!hold && ld_use) begin
      rwe_id_d = 1'b0;
      st_op_id_d = 1'b0;
      ld_op_id_d = 1'b0;
      valid_id_d = 1'b0;
    end else if (!hold) begin
      areg_d = a_fwd;
      breg_d = b_val;
      rd_id_d = rd_mod;
      com_id_d = com;
      rwe_id_d = dec.rwe;
      st_op_id_d = dec.st_op;
      ld_op_id_d = dec.ld_op;
      valid_id_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q <= NOP;
      areg_q <= '0;
      breg_q <= '0;
      rd_id_q <= '0;
      com_id_q <= '0;
      rwe_id_q <= 1'b0;
      st_op_id_q <= 1'b0;
      ld_op_id_q <= 1'b0;
      valid_id_q <= 1'b0;
    end else begin
      ir_q <= ir_d;
      areg_q <= areg_d;
      breg_q <= breg_d;
      rd_id_q <= rd_id_d;
      com_id_q <= com_id_d;
      rwe_id_q <= rwe_id_d;
      st_op_id_q <= st_op_id_d;
      ld_op_id_q <= ld_op_id_d;
      valid_id_q <= valid_id_d;
    end
  end
  assign stall_if = stall;
  assign pc_sel = stall ? PC_SEQ : dec.pc_sel;
  assign jr_sel = dec.jr_sel;
  assign jmp8 = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign jmp11 = {{(DW-11){ir_q[10]}}, ir_q[10:0]};
  assign jmpr = a_fwd;
  assign areg = areg_q;
  assign breg = breg_q;
  assign rd_id = rd_id_q;
  assign com_id = com_id_q;
  assign rwe_id = rwe_id_q;
  assign st_op_id = st_op_id_q;
  assign ld_op_id = ld_op_id_q;
  assign valid_id = valid_id_q;
endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage for the 5-stage pipelined CPU: generic data width DW, two-level forwarding (EX and MEM), write-through register file, load-use interlock, downstream hold and a selectable branch-delay-slot mode. Sits between the fetch stage (IR source, PC control) and the execute stage (ID/EX register outputs). Branches resolve here, using the fully forwarded A operand.

## Interface
Parameters:
- DW, 16, datapath/register width (≥16)
- DELAY_SLOT, 1, 1: the instruction after a taken branch/jump executes; 0: it is squashed to NOP

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; rst_n, synchronous, active-low; clock clk
- op  in  16  fetched instruction
- pc_next  in  DW  PC+1 of the fetched instruction (link value)
- hold  in  1  downstream stall; freezes this stage
- ex_result  in  DW  ALU result of the instruction in EX
- rd_mem, rwe_mem, mem_result  in  3/1/DW  MEM-stage destination, write enable, data
- rd_wb, rwe_wb, wb_data  in  3/1/DW  write-back port
- stall_if  out  1  IF must hold PC and not advance op
- pc_sel  out  2  next-PC select from `decoder`
- jr_sel  out  1  jump-register select
- jmp8, jmp11, jmpr  out  DW  sign-extended imm8, sign-extended imm11, forwarded A operand
- areg, breg  out  DW  ID/EX operands
- com_id  out  3  ALU command
- rwe_id, st_op_id, ld_op_id, valid_id  out  1  ID/EX controls
- rd_id  out  3  ID/EX destination

## Operation
- IR fields: opcode[15:11], rd[10:8], rs[7:5], func[4:0], imm8[7:0], imm11[10:0]. NOP = 16'h0000.
- `decoder` (unchanged) supplies pc_sel, com_sel, alu_bsel, jr_sel, rd_sel, rwe, st_op, ld_op. rd_sel=1 forces destination 7 and B = pc_next (link).
- B immediate by alu_bsel: 0 register, 1 sign-ext imm8, 2 zero-ext imm8, 3 {imm8,8'h00} zero-extended to DW.
- com_id source: com_sel 0 func[2:0], 1 THB, 2 ADD.
- Operand resolution per source (A addr = rd_mod, B addr = rs), priority: EX (rwe_id & rd_id match, ex_result) > MEM (rwe_mem & match) > WB (rwe_wb & match, wb_data) > register file. B forwarding applies only when alu_bsel=0 and rd_sel=0.
- Branch flags from forwarded A: zerof = (A==0), posf = !A[DW-1] & (A!=0).
- Load-use: ld_op_id & rwe_id & rd_id matches a used source → stall.
- Stall (load-use) or hold: pc_sel forced 0, stall_if=1, IR unchanged. Load-use inserts bubble into ID/EX (rwe/st/ld/valid_id=0, rest don't-care); hold leaves ID/EX unchanged.
- DELAY_SLOT=0 and pc_sel≠0 while not stalled: IR loads NOP instead of op.

## Timing
- Reset: IR=0, areg=breg=0, rd_id=0, com_id=0, rwe_id=st_op_id=ld_op_id=valid_id=0, all 8 registers=0; stall_if=0.
- Decode, branch resolution and stall_if are combinational from IR and forwarding inputs within the cycle; ID/EX outputs valid one cycle after IR load.
- Load-use costs exactly 1 bubble; the next cycle resolves from MEM.
- hold dominates load-use; a load-use pending at hold release still stalls 1 cycle.
- WB write and same-cycle read of the same register returns wb_data; writes to any register (incl. 0) are stored.
- Reset asserted mid-stall clears everything, including a pending squash.

## Structure
- def.h holds opcodes, func codes, THB/ADD, NOP; widths stay local parameters.
- Sub-module `regfile_p` (#(DW)): 8×DW, 2 async read, 1 sync write, synchronous reset; bypass priority logic stays in id_stage_p.
- Reuses `decoder`, `sel2`, `sel4` parametrised on DW.

## Test plan
- Reset, then NOPs → all outputs 0, valid_id=1 after first NOP, stall_if=0.
- ADD r1←5, then consumer of r1 → areg/breg=5 via EX forward; with one intervening NOP → via MEM; with two → via WB bypass.
- LD r2, then ADD r3,r2 → stall_if=1 one cycle, bubble (valid_id=0), then breg=mem_result.
- Branch-if-zero on r4 with r4 just written 0 → pc_sel≠0 same cycle; DELAY_SLOT=0: next ID/EX entry is NOP; DELAY_SLOT=1: fetched op executes.
- hold=1 three cycles during a taken branch → pc_sel=0, outputs frozen; branch fires on release.
- DW=32: ORI with imm8=0x80 → breg=0x00000080; LDI-high imm8=0x80 → 0x00008000; jmp11=0x400 → 0xFFFFFC00.
